// File: rtl/ebus_pkg.sv
// ebus_pkg: shared FSM states, address regions and chip-select decode for the external bus controller
package ebus_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_CAPTURE, S_HOLD} state_t;
  localparam logic [3:0] REG_UART0 = 4'd0;
  localparam logic [3:0] REG_UART1 = 4'd1;
  localparam logic [3:0] REG_UART2 = 4'd2;
  localparam logic [3:0] REG_UART3 = 4'd3;
  localparam logic [3:0] REG_PIC   = 4'd4;
  localparam int CS_UART0 = 4;
  localparam int CS_UART1 = 3;
  localparam int CS_UART2 = 2;
  localparam int CS_UART3 = 1;
  localparam int CS_PIC   = 0;
  // region n maps to CS bit (4-n); anything above PIC is unmapped
  function automatic logic [4:0] decode(input logic [3:0] r);
    return (r <= REG_PIC) ? (5'b10000 >> r) : 5'b00000;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser, async active-low reset, resets to 1
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/ebus_cycle_ctrl.sv
// ebus_cycle_ctrl: async CPU bus to peripheral mux cycle controller with decode, strobes and wait states
module ebus_cycle_ctrl
  import ebus_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int WS = 2
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic [AW-1:0] ADDR,
  input  logic          nCS,
  input  logic          nOE,
  input  logic          nWE,
  input  logic [DW-1:0] DI_BUS,
  output logic [DW-1:0] DO_BUS,
  output logic          DOE,
  output logic          nRDY,
  output logic [4:0]    CS,
  output logic          nRW,
  output logic          RD_STB,
  output logic          WR_STB,
  output logic [3:0]    PADDR,
  output logic [DW-1:0] WDATA,
  input  logic [DW-1:0] RDATA,
  output logic          ERR
);
  logic s_cs, s_oe, s_we, armed, start;
  logic [1:0] live;
  logic [3:0] cnt;
  state_t state, nxt;
  sync2 u_cs (.clk(clk), .rst_n(nRST), .d(nCS), .q(s_cs));
  sync2 u_oe (.clk(clk), .rst_n(nRST), .d(nOE), .q(s_oe));
  sync2 u_we (.clk(clk), .rst_n(nRST), .d(nWE), .q(s_we));
  always_comb begin
    start = (state == S_IDLE) && armed && !s_cs && (s_oe ^ s_we);
    nxt = state;
    case (state)
      S_IDLE:    nxt = start ? S_SETUP : S_IDLE;
      S_SETUP:   nxt = s_cs ? S_IDLE : S_STROBE;
      S_STROBE:  nxt = s_cs ? S_IDLE : (WS == 0) ? S_CAPTURE : S_WAIT;
      S_WAIT:    nxt = s_cs ? S_IDLE : (cnt == 4'd0) ? S_CAPTURE : S_WAIT;
      S_CAPTURE: nxt = S_HOLD;
      S_HOLD:    nxt = (s_cs || (nRW ? s_we : s_oe)) ? S_IDLE : S_HOLD;
      default:   nxt = S_IDLE;
    endcase
  end
  // live masks the synchronisers' reset-value 1s so a held nCS cannot arm IDLE after reset
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= S_IDLE;
      live   <= 2'b00;
      armed  <= 1'b0;
      cnt    <= 4'd0;
      CS     <= 5'b0;
      nRW    <= 1'b1;
      RD_STB <= 1'b0;
      WR_STB <= 1'b0;
      PADDR  <= 4'd0;
      WDATA  <= '0;
      DO_BUS <= '0;
      DOE    <= 1'b0;
      nRDY   <= 1'b1;
      ERR    <= 1'b0;
    end else begin
      state  <= nxt;
      live   <= {live[0], 1'b1};
      armed  <= (state == S_IDLE) && !start && (armed || (s_cs && live[1]));
      cnt    <= (state == S_WAIT) ? cnt - 4'd1 : 4'(WS - 1);
      RD_STB <= (nxt == S_STROBE) && !nRW;
      WR_STB <= (nxt == S_STROBE) && nRW && (CS != 5'b0);
      nRDY   <= !(nxt inside {S_SETUP, S_STROBE, S_WAIT, S_CAPTURE});
      DOE    <= (nxt == S_HOLD) && !nRW;
      ERR    <= ERR || ((state == S_IDLE) && !s_cs && !s_oe && !s_we);
      if (start) begin
        CS    <= decode(ADDR[7:4]);
        PADDR <= ADDR[3:0];
        nRW   <= s_oe;
        if (!s_we) WDATA <= DI_BUS;
      end else if (nxt == S_IDLE) begin
        CS  <= 5'b0;
        nRW <= 1'b1;
      end
      if (state == S_CAPTURE && !nRW) DO_BUS <= RDATA;
    end
  end
endmodule

// File: tb/tb_ebus_cycle_ctrl.sv
// tb_ebus_cycle_ctrl: directed checks on three controllers built with WS = 0, 2 and 4
module tb_ebus_cycle_ctrl;
  logic clk = 1'b0;
  logic nRST, nCS, nOE, nWE;
  logic [7:0] ADDR;
  logic [15:0] DI_BUS, RDATA;
  logic [15:0] do_b [3];
  logic [15:0] wdata [3];
  logic [4:0] cs [3];
  logic [3:0] paddr [3];
  logic doe [3];
  logic nrdy [3];
  logic nrw [3];
  logic rds [3];
  logic wrs [3];
  logic err [3];
  int checks = 0, errors = 0;
  int n_rd, n_wr, n_wait, n_doe, n_cs;
  always #5 clk = ~clk;
  // instance g runs with WS = 2*g
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ebus_cycle_ctrl #(.AW(8), .DW(16), .WS(2 * g)) u_dut (
      .clk(clk), .nRST(nRST), .ADDR(ADDR), .nCS(nCS), .nOE(nOE), .nWE(nWE),
      .DI_BUS(DI_BUS), .DO_BUS(do_b[g]), .DOE(doe[g]), .nRDY(nrdy[g]), .CS(cs[g]),
      .nRW(nrw[g]), .RD_STB(rds[g]), .WR_STB(wrs[g]), .PADDR(paddr[g]),
      .WDATA(wdata[g]), .RDATA(RDATA), .ERR(err[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input int k);
    n_rd = 0; n_wr = 0; n_wait = 0; n_doe = 0; n_cs = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      n_rd += int'(rds[k]);
      n_wr += int'(wrs[k]);
      n_wait += int'(!nrdy[k]);
      n_doe += int'(doe[k]);
      n_cs += int'(cs[k] != 5'b0);
    end
  endtask
  initial begin
    nRST = 1'b0; nCS = 1'b1; nOE = 1'b1; nWE = 1'b1;
    ADDR = 8'h00; DI_BUS = 16'h0; RDATA = 16'h0;
    cyc(); cyc();
    chk("rst_cs", cs[1], 5'b0);
    chk("rst_nrdy", nrdy[1], 1'b1);
    chk("rst_nrw", nrw[1], 1'b1);
    chk("rst_err", err[1], 1'b0);
    chk("rst_do", do_b[1], 16'h0);
    chk("rst_doe", doe[1], 1'b0);
    chk("rst_paddr", paddr[1], 4'h0);
    nRST = 1'b1;
    run(5, 1);
    // read UART2 on WS=2
    ADDR = 8'h25; RDATA = 16'hA5C3; nCS = 1'b0; nOE = 1'b0;
    run(10, 1);
    chk("rd_stb_cnt", n_rd, 1);
    chk("rd_wait_cnt", n_wait, 5);
    chk("rd_cs", cs[1], 5'b00100);
    chk("rd_paddr", paddr[1], 4'h5);
    chk("rd_nrw", nrw[1], 1'b0);
    chk("rd_doe", doe[1], 1'b1);
    chk("rd_do", do_b[1], 16'hA5C3);
    nCS = 1'b1; nOE = 1'b1;
    run(3, 1);
    chk("rd_end_doe", doe[1], 1'b0);
    chk("rd_end_cs", cs[1], 5'b0);
    chk("rd_end_nrw", nrw[1], 1'b1);
    chk("rd_end_do", do_b[1], 16'hA5C3);
    run(3, 0);
    // write PIC on WS=0
    ADDR = 8'h41; DI_BUS = 16'h1234; nCS = 1'b0; nWE = 1'b0;
    run(8, 0);
    chk("wr_stb_cnt", n_wr, 1);
    chk("wr_doe_cnt", n_doe, 0);
    chk("wr_wait_cnt", n_wait, 3);
    chk("wr_cs", cs[0], 5'b00001);
    chk("wr_wdata", wdata[0], 16'h1234);
    chk("wr_nrw", nrw[0], 1'b1);
    nCS = 1'b1; nWE = 1'b1;
    run(6, 0);
    // unmapped read and write on WS=2
    ADDR = 8'hF0; RDATA = 16'hBEEF; nCS = 1'b0; nOE = 1'b0;
    run(10, 1);
    chk("um_rd_stb", n_rd, 1);
    chk("um_rd_cs", n_cs, 0);
    chk("um_rd_do", do_b[1], 16'hBEEF);
    nCS = 1'b1; nOE = 1'b1;
    run(6, 1);
    DI_BUS = 16'h5555; nCS = 1'b0; nWE = 1'b0;
    run(10, 1);
    chk("um_wr_stb", n_wr, 0);
    chk("um_wr_wait", n_wait, 5);
    nCS = 1'b1; nWE = 1'b1;
    run(6, 1);
    // abort on WS=4: nCS rises one cycle after STROBE
    ADDR = 8'h12; RDATA = 16'h1111; nCS = 1'b0; nOE = 1'b0;
    run(4, 2);
    chk("ab_stb", rds[2], 1'b1);
    chk("ab_cs_live", cs[2], 5'b01000);
    cyc();
    nCS = 1'b1; nOE = 1'b1;
    run(2, 2);
    chk("ab_still_wait", nrdy[2], 1'b0);
    run(1, 2);
    chk("ab_nrdy", nrdy[2], 1'b1);
    chk("ab_cs", cs[2], 5'b0);
    chk("ab_do", do_b[2], 16'hBEEF);
    run(5, 2);
    chk("ab_no_stb", n_rd, 0);
    chk("ab_no_wait", n_wait, 0);
    chk("ab_do_hold", do_b[2], 16'hBEEF);
    run(4, 1);
    // protocol error, then a legal read with ERR sticky
    nCS = 1'b0; nOE = 1'b0; nWE = 1'b0;
    run(8, 1);
    chk("pe_err", err[1], 1'b1);
    chk("pe_cs", n_cs, 0);
    chk("pe_rd", n_rd, 0);
    chk("pe_wr", n_wr, 0);
    chk("pe_wait", n_wait, 0);
    nCS = 1'b1; nOE = 1'b1; nWE = 1'b1;
    run(4, 1);
    ADDR = 8'h30; RDATA = 16'h5A5A; nCS = 1'b0; nOE = 1'b0;
    run(10, 1);
    chk("pe_rd_cs", cs[1], 5'b00010);
    chk("pe_rd_do", do_b[1], 16'h5A5A);
    chk("pe_err_sticky", err[1], 1'b1);
    nCS = 1'b1; nOE = 1'b1;
    run(4, 1);
    // reset during WAIT, nCS held low through release
    ADDR = 8'h05; RDATA = 16'h7777; nCS = 1'b0; nOE = 1'b0;
    run(5, 1);
    chk("mr_in_wait", nrdy[1], 1'b0);
    nRST = 1'b0;
    #1;
    chk("mr_cs", cs[1], 5'b0);
    chk("mr_nrdy", nrdy[1], 1'b1);
    chk("mr_do", do_b[1], 16'h0);
    chk("mr_err", err[1], 1'b0);
    chk("mr_nrw", nrw[1], 1'b1);
    chk("mr_paddr", paddr[1], 4'h0);
    chk("mr_rdstb", rds[1], 1'b0);
    run(2, 1);
    nRST = 1'b1;
    run(10, 1);
    chk("mr_no_retrig_wait", n_wait, 0);
    chk("mr_no_retrig_rd", n_rd, 0);
    chk("mr_no_retrig_cs", n_cs, 0);
    nCS = 1'b1; nOE = 1'b1;
    run(4, 1);
    RDATA = 16'h0F0F; nCS = 1'b0; nOE = 1'b0;
    run(10, 1);
    chk("mr_new_rd", n_rd, 1);
    chk("mr_new_do", do_b[1], 16'h0F0F);
    chk("mr_new_paddr", paddr[1], 4'h5);
    chk("mr_new_cs", cs[1], 5'b10000);
    nCS = 1'b1; nOE = 1'b1;
    run(3, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ebus_cycle_ctrl.md
Name: ebus_cycle_ctrl

Overview:
- Bus-cycle controller between the processor's asynchronous external memory bus (nCS/nOE/nWE/ADDR) and the FPGA peripheral data-bus mux (UART0..3, PIC, console default).
- Synchronises the strobes and decodes the address into one-hot peripheral chip selects.
- Issues single-cycle read/write strobes and inserts programmable wait states via nRDY.
- Latches read data and drives the CPU data-bus output enable.

Parameters:
AW, 8, CPU address width (ADDR[AW-1:0]); minimum 8.
DW, 16, data width; matches peripheral mux width.
WS, 2, wait cycles between strobe and data capture (0..15).

Ports:
clk  in  1  system clock
nRST  in  1  asynchronous active-low reset
ADDR  in  AW  CPU address, stable while nCS low
nCS  in  1  CPU chip select, active low, asynchronous
nOE  in  1  CPU read strobe, active low, asynchronous
nWE  in  1  CPU write strobe, active low, asynchronous
DI_BUS  in  DW  CPU write data
DO_BUS  out  DW  latched read data to CPU pads
DOE  out  1  CPU data pad output enable
nRDY  out  1  wait request to CPU, low = wait
CS  out  5  one-hot peripheral select {UART0,UART1,UART2,UART3,PIC}, bit4 = UART0
nRW  out  1  to peripheral mux, 0 = read cycle
RD_STB  out  1  one-cycle read strobe
WR_STB  out  1  one-cycle write strobe
PADDR  out  4  latched ADDR[3:0], register offset
WDATA  out  DW  latched write data
RDATA  in  DW  read data from peripheral mux
ERR  out  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Reset (async, nRST low), all outputs forced: CS=0, nRW=1, RD_STB=0, WR_STB=0, PADDR=0, WDATA=0, DO_BUS=0, DOE=0, nRDY=1, ERR=0. FSM goes to IDLE; synchronisers load 1. Reset mid-cycle aborts immediately; no strobe completes.
- Synchronisation: nCS, nOE, nWE each pass through a 2-FF synchroniser. ADDR and DI_BUS are sampled unsynchronised in SETUP; the CPU holds them stable.
- Decode on ADDR[7:4]: 0..3 → UART0..3, 4 → PIC, anything else → unmapped (CS=0).
- IDLE:
  - Start when synced nCS=0 and exactly one of nOE/nWE is 0.
  - If nOE and nWE are both 0 with nCS=0: set ERR, stay in IDLE.
- SETUP (1 cycle):
  - Latch PADDR and CS.
  - Write: latch WDATA=DI_BUS.
  - Set nRW=0 for a read, 1 for a write.
  - Drive nRDY=0.
- STROBE (1 cycle):
  - Read: RD_STB=1, also on unmapped (mux then returns console data).
  - Write: WR_STB=1 only if mapped; unmapped write produces no strobe.
- WAIT: counts WS cycles; skipped when WS=0.
- CAPTURE (1 cycle): read → DO_BUS<=RDATA.
- HOLD:
  - nRDY=1.
  - Read: DOE=1.
  - Leave to IDLE when synced nCS=1 or the active strobe deasserts.
  - On exit: CS=0, nRW=1, DOE=0. DO_BUS holds its value.
- Latency: from first edge at which nCS and the strobe are sampled low, the FSM enters SETUP on edge +2, STROBE +3, CAPTURE +4+WS, HOLD +5+WS.
- Abort: synced nCS=1 in SETUP, STROBE or WAIT → IDLE next edge. CS=0, nRDY=1, DO_BUS unchanged, and no further strobe is issued.
- Back-to-back cycles: a new cycle may start only after IDLE has observed synced nCS=1 at least once. An nCS held low from the previous cycle does not retrigger.
- nRDY is registered, low only in SETUP, STROBE, WAIT and CAPTURE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package ebus_pkg: state encoding (IDLE, SETUP, STROBE, WAIT, CAPTURE, HOLD); region constants REG_UART0..REG_UART3=0..3, REG_PIC=4; CS bit positions.
- Sub-module sync2: 2-flop synchroniser with async active-low reset and reset value 1. Instantiated three times.

Test Plan:
- Read UART2, WS=2: ADDR=8'h25, nCS/nOE low, RDATA=16'hA5C3 → CS=5'b00100, PADDR=5, one RD_STB pulse, nRDY low for 5 cycles, DO_BUS=16'hA5C3, DOE=1 until nOE rises.
- Write PIC, WS=0: ADDR=8'h41, DI_BUS=16'h1234, nWE low → CS=5'b00001, WDATA=16'h1234, exactly one WR_STB, nRW=1, DOE stays 0.
- Unmapped: read at ADDR=8'hF0 → CS=0, RD_STB pulses, DO_BUS=RDATA. Write at ADDR=8'hF0 → no WR_STB, nRDY still sequences.
- Abort: nCS rises one cycle after STROBE with WS=4 → next edge IDLE, nRDY=1, CS=0, DO_BUS unchanged.
- Protocol error: nCS, nOE and nWE all low → ERR=1, no CS/strobe. ERR stays 1 after a following legal read; cleared only by nRST.
- Reset mid-WAIT: nRST low during WAIT → all outputs return to reset values asynchronously. After release with nCS still low, no cycle starts until nCS goes high then low again.
